// File: rtl/seq_chunk_adder.sv
// Multicycle add/subtract unit: WIDTH-bit result built CHUNK bits per clock, LSB slice first.
// Define SEQ_ADDER_FLAGS_EN to build the ovf/zero flag logic; otherwise both flags read 0.
module seq_chunk_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW    = CHUNK + 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   part_q, part_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
`ifdef SEQ_ADDER_FLAGS_EN
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               top_cin;
`endif

  // One CHUNK-bit ripple slice: the whole critical path of the unit.
  logic [CHUNK-1:0]   slice_a, slice_b, slice_s;
  logic               slice_co;
  logic [WIDTH-1:0]   part_next;

  assign slice_a = a_q[CHUNK-1:0];
  assign slice_b = b_q[CHUNK-1:0];
  assign {slice_co, slice_s} = CW'(slice_a) + CW'(slice_b) + CW'(carry_q);
  assign part_next = WIDTH'({slice_s, part_q} >> CHUNK);

`ifdef SEQ_ADDER_FLAGS_EN
  // Carry into the slice MSB recovered from the sum bit and its two addend bits.
  assign top_cin = slice_a[CHUNK-1] ^ slice_b[CHUNK-1] ^ slice_s[CHUNK-1];
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    ready_d = ready_q;
`ifdef SEQ_ADDER_FLAGS_EN
    ovf_d   = ovf_q;
    zero_d  = zero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          part_d  = '0;
          ready_d = 1'b0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = slice_co;
        part_d  = part_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_SLICE) begin
          sum_d   = part_next;
          cout_d  = slice_co;
`ifdef SEQ_ADDER_FLAGS_EN
          ovf_d   = top_cin ^ slice_co;
          zero_d  = (part_next == '0);
`endif
          cnt_d   = '0;
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef SEQ_ADDER_FLAGS_EN
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      ready_q <= ready_d;
`ifdef SEQ_ADDER_FLAGS_EN
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
`ifdef SEQ_ADDER_FLAGS_EN
  assign ovf   = ovf_q;
  assign zero  = zero_q;
`else
  assign ovf   = 1'b0;
  assign zero  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: directed operations checked against a transaction-level model
// every cycle, plus hand-computed literal results. CHUNK is a bench parameter.
module tb_seq_chunk_adder;

  localparam int unsigned WIDTH = 16;
  parameter  int unsigned CHUNK = 4;
  localparam int unsigned N     = WIDTH / CHUNK;
`ifdef SEQ_ADDER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .ready(ready), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk_v(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_b(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic from integer semantics.
  function automatic logic [WIDTH-1:0] ref_sum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic s);
    return s ? (x - y) : (x + y);
  endfunction

  function automatic logic ref_cout(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    longint ux = longint'(x);
    longint uy = longint'(y);
    if (s) return (ux >= uy);
    return ((ux + uy) >= (longint'(1) << WIDTH));
  endfunction

  function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint r  = s ? (sx - sy) : (sx + sy);
    return FLAGS && ((r > ((longint'(1) << (WIDTH - 1)) - 1)) || (r < -(longint'(1) << (WIDTH - 1))));
  endfunction

  // Transaction model: an accepted op completes exactly N edges later.
  int               cyc = 0;
  logic             m_busy;
  int               m_due;
  logic [WIDTH-1:0] p_sum;
  logic             p_cout, p_ovf, p_zero;
  logic             exp_ready, exp_done, exp_cout, exp_ovf, exp_zero;
  logic [WIDTH-1:0] exp_sum;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy    <= 1'b0;
      m_due     <= 0;
      exp_ready <= 1'b1;
      exp_done  <= 1'b0;
      exp_sum   <= '0;
      exp_cout  <= 1'b0;
      exp_ovf   <= 1'b0;
      exp_zero  <= 1'b0;
    end else begin
      exp_done <= 1'b0;
      if (!m_busy && start) begin
        m_busy    <= 1'b1;
        m_due     <= cyc + int'(N);
        exp_ready <= 1'b0;
        p_sum     <= ref_sum(a, b, sub);
        p_cout    <= ref_cout(a, b, sub);
        p_ovf     <= ref_ovf(a, b, sub);
        p_zero    <= FLAGS && (ref_sum(a, b, sub) == '0);
      end else if (m_busy && cyc == m_due) begin
        m_busy    <= 1'b0;
        exp_ready <= 1'b1;
        exp_done  <= 1'b1;
        exp_sum   <= p_sum;
        exp_cout  <= p_cout;
        exp_ovf   <= p_ovf;
        exp_zero  <= p_zero;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk_b("ready", ready, exp_ready);
    chk_b("done", done, exp_done);
    chk_v("sum", sum, exp_sum);
    chk_b("cout", cout, exp_cout);
    chk_b("ovf", ovf, exp_ovf);
    chk_b("zero", zero, exp_zero);
  end

  // Issue one op from a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic ts,
                        input bit poke, output int lat);
    int limit = 4 * int'(N) + 8;
    chk_b("ready_before_start", ready, 1'b1);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    sub   = ts;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    sub   = 1'($urandom);
    if (poke) begin
      start = 1'b1;
      a     = 16'hAAAA;
    end
    lat = 0;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: no done within %0d cycles", limit);
    end
  endtask

  logic [WIDTH-1:0] t_a   [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
  logic [WIDTH-1:0] t_b   [5] = '{16'h1111, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
  logic             t_sub [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [WIDTH-1:0] t_sum [5] = '{16'h2345, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
  logic             t_co  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic             t_ov  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic             t_z   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int lat;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk_b("rst_ready", ready, 1'b1);
    chk_b("rst_done", done, 1'b0);
    chk_v("rst_sum", sum, 16'h0000);
    chk_b("rst_cout", cout, 1'b0);
    chk_b("rst_ovf", ovf, 1'b0);
    chk_b("rst_zero", zero, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_op(t_a[i], t_b[i], t_sub[i], 1'b0, lat);
      chk_i("latency", lat, int'(N));
      chk_v("lit_sum", sum, t_sum[i]);
      chk_b("lit_cout", cout, t_co[i]);
      chk_b("lit_ovf", ovf, FLAGS & t_ov[i]);
      chk_b("lit_zero", zero, FLAGS & t_z[i]);
    end

    // Start while busy is ignored; start in the done cycle is taken.
    run_op(16'h0001, 16'h0002, 1'b0, 1'b1, lat);
    chk_i("poke_latency", lat, int'(N));
    chk_v("poke_sum", sum, 16'h0003);
    run_op(16'h0010, 16'h0020, 1'b0, 1'b0, lat);
    chk_i("b2b_latency", lat, int'(N));
    chk_v("b2b_sum", sum, 16'h0030);

    // Reset two cycles after accept aborts the op.
    @(negedge clk);
    start = 1'b1;
    a     = 16'h0003;
    b     = 16'h0004;
    sub   = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_b("abort_ready", ready, 1'b1);
    chk_b("abort_done", done, 1'b0);
    chk_v("abort_sum", sum, 16'h0000);
    chk_b("abort_cout", cout, 1'b0);
    chk_b("abort_ovf", ovf, 1'b0);
    chk_b("abort_zero", zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (N + 3) @(negedge clk);

    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
    chk_v("recover_sum", sum, 16'h0100);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
